// File: rtl/ib_up_link_arbiter.sv
// Packet-atomic round-robin merge of PORTS IB_UP transmit streams onto one link.
// Zero-latency mux; grant locks from the SOP transfer to the owner's EOP transfer.
module ib_up_link_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   in_data,
  input  logic [PORTS-1:0]              in_sop_n,
  input  logic [PORTS-1:0]              in_eop_n,
  input  logic [PORTS-1:0]              in_src_rdy_n,
  output logic [PORTS-1:0]              in_dst_rdy_n,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_sop_n,
  output logic                          out_eop_n,
  output logic                          out_src_rdy_n,
  input  logic                          out_dst_rdy_n,
  output logic                          busy,
  output logic [$clog2(PORTS)-1:0]      owner
);

  localparam int PW = $clog2(PORTS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   sel_idle;
  logic [PW-1:0]   sel;
  logic            found;
  logic            active;
  logic            xfer;
  logic [PORTS-1:0] req;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-2 port counts never reach an unused index.
    return (p == PW'(PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req = ~in_src_rdy_n & ~in_sop_n;

  always_comb begin
    int idx;
    found    = 1'b0;
    sel_idle = '0;
    idx      = 0;
    for (int k = 0; k < PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && req[idx]) begin
        found    = 1'b1;
        sel_idle = PW'(idx);
      end
    end
  end

  assign sel    = (state == LOCKED) ? owner_q : sel_idle;
  assign active = reset_n && ((state == LOCKED) || found);

  always_comb begin
    out_data      = '0;
    out_sop_n     = 1'b1;
    out_eop_n     = 1'b1;
    out_src_rdy_n = 1'b1;
    in_dst_rdy_n  = '1;
    if (active) begin
      out_data          = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
      out_sop_n         = in_sop_n[sel];
      out_eop_n         = in_eop_n[sel];
      out_src_rdy_n     = in_src_rdy_n[sel];
      in_dst_rdy_n[sel] = out_dst_rdy_n;
    end
  end

  assign xfer  = !out_src_rdy_n && !out_dst_rdy_n;
  assign busy  = (state == LOCKED);
  assign owner = reset_n ? sel : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner_q <= '0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          if (out_eop_n) begin
            state   <= LOCKED;
            owner_q <= sel;
          end else begin
            rr_ptr <= next_port(sel);
          end
        end
        LOCKED: if (xfer && !out_eop_n) begin
          state  <= IDLE;
          rr_ptr <= next_port(owner_q);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
